// File: rtl/rs_lat_drv.sv
// Turns each accepted valid/ready command into one PULSE_W-cycle s or r pulse, a GUARD_W-cycle gap and a one-cycle done.
// Done comes PULSE_W+GUARD_W+1 cycles after the handshake (1 cycle when redundant); req_ready is low for the whole sequence.
module rs_lat_drv #(
    parameter int PULSE_W        = 4,
    parameter int GUARD_W        = 2,
    parameter int CNT_W          = 8,
    parameter int SKIP_REDUNDANT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_val,
    output logic req_ready,
    output logic s,
    output logic r,
    output logic busy,
    output logic done,
    output logic shadow
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_W - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             val_q, val_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             shadow_q, shadow_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        val_d    = val_q;
        s_d      = s_q;
        r_d      = r_q;
        shadow_d = shadow_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    // A command matching the believed latch state needs no pulse.
                    if ((SKIP_REDUNDANT != 0) && (req_val == shadow_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        val_d   = req_val;
                        cnt_d   = PULSE_LD;
                        s_d     = req_val;
                        r_d     = ~req_val;
                        state_d = ST_PULSE;
                    end
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    s_d      = 1'b0;
                    r_d      = 1'b0;
                    shadow_d = val_q;
                    if (GUARD_W > 0) begin
                        cnt_d   = GUARD_LD;
                        state_d = ST_GUARD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GUARD: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            val_q    <= 1'b0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            shadow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            val_q    <= val_d;
            s_q      <= s_d;
            r_q      <= r_d;
            shadow_q <= shadow_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE) && rst;
    assign s         = s_q;
    assign r         = r_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign shadow    = shadow_q;

endmodule

// File: tb/tb_rs_lat_drv.sv
// Bench for rs_lat_drv: cycle table on the default build, plus short sequences on SKIP_REDUNDANT=0 and PULSE_W=1/GUARD_W=0 builds.
module tb_rs_lat_drv;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic vld_a = 1'b0, val_a = 1'b0;
    logic rdy_a, s_a, r_a, busy_a, done_a, shadow_a;
    logic vld_b = 1'b0, val_b = 1'b0;
    logic rdy_b, s_b, r_b, busy_b, done_b, shadow_b;
    logic vld_c = 1'b0, val_c = 1'b0;
    logic rdy_c, s_c, r_c, busy_c, done_c, shadow_c;

    rs_lat_drv u_a (
        .clk(clk), .rst(rst), .req_valid(vld_a), .req_val(val_a), .req_ready(rdy_a),
        .s(s_a), .r(r_a), .busy(busy_a), .done(done_a), .shadow(shadow_a)
    );

    rs_lat_drv #(.SKIP_REDUNDANT(0)) u_b (
        .clk(clk), .rst(rst), .req_valid(vld_b), .req_val(val_b), .req_ready(rdy_b),
        .s(s_b), .r(r_b), .busy(busy_b), .done(done_b), .shadow(shadow_b)
    );

    rs_lat_drv #(.PULSE_W(1), .GUARD_W(0)) u_c (
        .clk(clk), .rst(rst), .req_valid(vld_c), .req_val(val_c), .req_ready(rdy_c),
        .s(s_c), .r(r_c), .busy(busy_c), .done(done_c), .shadow(shadow_c)
    );

    // exp packs {s, r, req_ready, busy, done, shadow} as seen just after the edge.
    typedef struct {
        logic       rst;
        logic       vld;
        logic       val;
        logic [5:0] exp;
    } vec_t;

    localparam int NVEC = 52;
    vec_t tbl [NVEC];

    int   checks  = 0;
    int   errors  = 0;
    logic overlap = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if ((s_a && r_a) || (s_b && r_b) || (s_c && r_c)) overlap = 1'b1;
    endtask

    task automatic setv(input int i, input logic rs, input logic vl, input logic va, input logic [5:0] e);
        tbl[i].rst = rs;
        tbl[i].vld = vl;
        tbl[i].val = va;
        tbl[i].exp = e;
    endtask

    // One command on the SKIP_REDUNDANT=0 build, observed for the 8 cycles it should occupy.
    task automatic cmd_b(input logic v, input string tag);
        int scnt = 0;
        int rcnt = 0;
        int donepos = -1;
        vld_b = 1'b1;
        val_b = v;
        for (int k = 0; k < 8; k++) begin
            tick();
            vld_b = 1'b0;
            if (s_b) scnt++;
            if (r_b) rcnt++;
            if (done_b) donepos = k;
        end
        chk({tag, "_s_cycles"}, scnt, v ? 4 : 0);
        chk({tag, "_r_cycles"}, rcnt, v ? 0 : 4);
        chk({tag, "_done_pos"}, donepos, 6);
        chk({tag, "_ready"}, {31'd0, rdy_b}, 1);
        chk({tag, "_busy"}, {31'd0, busy_b}, 0);
        chk({tag, "_shadow"}, {31'd0, shadow_b}, {31'd0, v});
    endtask

    initial begin
        int   dones = 0;
        int   c, p;
        logic v;

        for (int i = 0; i < 3; i++) setv(i, 1'b0, 1'b1, 1'b1, 6'b000000);
        setv(3,  1'b1, 1'b0, 1'b0, 6'b001000);
        setv(4,  1'b1, 1'b1, 1'b1, 6'b100100);
        for (int i = 5; i < 8; i++) setv(i, 1'b1, 1'b0, 1'b0, 6'b100100);
        setv(8,  1'b1, 1'b0, 1'b0, 6'b000101);
        setv(9,  1'b1, 1'b0, 1'b0, 6'b000101);
        setv(10, 1'b1, 1'b0, 1'b0, 6'b000111);
        setv(11, 1'b1, 1'b0, 1'b0, 6'b001001);
        setv(12, 1'b1, 1'b1, 1'b1, 6'b000111);
        setv(13, 1'b1, 1'b0, 1'b0, 6'b001001);
        // Four back-to-back commands r,s,r,s with valid held; req_val flips while busy.
        for (int i = 14; i < 46; i++) begin
            c = (i - 14) / 8;
            p = (i - 14) % 8;
            v = c[0];
            case (p)
                0, 1, 2, 3: setv(i, 1'b1, 1'b1, (p == 0) ? v : ~v, {v, ~v, 1'b0, 1'b1, 1'b0, ~v});
                4, 5:       setv(i, 1'b1, 1'b1, ~v, {4'b0001, 1'b0, v});
                6:          setv(i, 1'b1, 1'b1, ~v, {4'b0001, 1'b1, v});
                default:    setv(i, 1'b1, 1'b1, ~v, {4'b0010, 1'b0, v});
            endcase
        end
        setv(46, 1'b1, 1'b1, 1'b0, 6'b010101);
        setv(47, 1'b1, 1'b0, 1'b0, 6'b010101);
        setv(48, 1'b0, 1'b0, 1'b0, 6'b000000);
        for (int i = 49; i < NVEC; i++) setv(i, 1'b1, 1'b0, 1'b0, 6'b001000);

        for (int i = 0; i < NVEC; i++) begin
            rst   = tbl[i].rst;
            vld_a = tbl[i].vld;
            val_a = tbl[i].val;
            tick();
            chk($sformatf("vec%0d", i), {26'd0, s_a, r_a, rdy_a, busy_a, done_a, shadow_a}, {26'd0, tbl[i].exp});
            if (i >= 14 && i < 46 && done_a) dones++;
        end
        chk("b2b_done_count", dones, 4);

        cmd_b(1'b1, "b_set");
        cmd_b(1'b1, "b_set_again");

        vld_c = 1'b1;
        val_c = 1'b1;
        tick();
        chk("c_pulse", {28'd0, s_c, r_c, busy_c, done_c}, 32'b1010);
        vld_c = 1'b0;
        val_c = 1'b0;
        tick();
        chk("c_done", {26'd0, s_c, r_c, busy_c, done_c, rdy_c, shadow_c}, 32'b001101);
        tick();
        chk("c_ready", {26'd0, s_c, r_c, busy_c, done_c, rdy_c, shadow_c}, 32'b000011);

        chk("no_overlap", {31'd0, overlap}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_lat_drv.md
Name: rs_lat_drv

Overview:
Sequencer that drives the r/s inputs of a set/reset latch from a valid/ready command stream. It converts each accepted command into a single clean, width-controlled set or reset pulse, followed by a guard gap. It keeps a shadow copy of the latch state so that redundant commands can be suppressed. It sits between control logic (e.g. a Wishbone register) and an rs_lat-style storage element.

Parameters:
PULSE_W, 4, active pulse length on s or r in clk cycles; legal range 1..2^CNT_W-1
GUARD_W, 2, dead cycles with both s and r low after every pulse; legal range 0..2^CNT_W-1
CNT_W, 8, width of the internal pulse/guard counter
SKIP_REDUNDANT, 1, when 1, a command equal to the shadow state produces no pulse

Ports:
clk  input  1  sole clock; all logic on the rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
req_valid  input  1  command present
req_val  input  1  requested latch value: 1 = set, 0 = reset
req_ready  output  1  block can accept a command this cycle
s  output  1  set pulse to latch, registered
r  output  1  reset pulse to latch, registered
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a command completes
shadow  output  1  believed latch state, updated at end of pulse

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, counter=0, s=0, r=0, done=0, busy=0, shadow=0, req_ready=1 from the following cycle. Reset overrides every state. Reset mid-pulse drops s/r on that edge. No guard period is applied after reset.
- States: IDLE, PULSE, GUARD, DONE.
- req_ready = (state==IDLE) && rst. It is combinational from state. A handshake occurs when req_valid && req_ready at an edge; call that edge N.
- IDLE, handshake, non-redundant (req_val!=shadow, or SKIP_REDUNDANT=0):
  - Latch req_val internally; go to PULSE with counter=PULSE_W-1.
  - s (if req_val=1) or r (if 0) is high from edge N for exactly PULSE_W cycles.
- PULSE: decrement counter each cycle. At counter==0:
  - Drive s/r low.
  - shadow <= latched req_val.
  - If GUARD_W>0, go to GUARD with counter=GUARD_W-1; otherwise go to DONE.
- GUARD: s=r=0; decrement counter; at counter==0 go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, req_ready=0; next state IDLE.
- Latency for a non-redundant command:
  - Pulse occupies cycles N+1..N+PULSE_W.
  - done is high in cycle N+PULSE_W+GUARD_W+1.
  - req_ready returns in cycle N+PULSE_W+GUARD_W+2.
- IDLE, handshake, redundant (SKIP_REDUNDANT=1 and req_val==shadow): no s/r activity, shadow unchanged; go straight to DONE, so done is high in N+1 and ready returns in N+2.
- Invariants:
  - s and r are never high in the same cycle.
  - Between any two pulses there are at least GUARD_W cycles plus 2 cycles (DONE, IDLE) with both low.
- req_valid while not ready: ignored. req_val is sampled only at the handshake edge; changes during busy have no effect.
- Back-to-back requests with req_valid held high: the next handshake occurs on the first IDLE cycle.
- Counter width: PULSE_W and GUARD_W are compared as CNT_W-bit unsigned values; no wrap occurs within the legal range.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 -> s=r=0, busy=0, done=0, shadow=0; req_ready=1 in the first cycle after rst=1.
- Set with defaults (PULSE_W=4, GUARD_W=2): handshake at N with req_val=1 -> s=1 in N+1..N+4, r=0 throughout, shadow=1 from N+5, done=1 only in N+7, req_ready=1 at N+8.
- Redundant command: after the set above, send req_val=1 -> no s/r pulse, done=1 in N+1, shadow stays 1. Repeat with SKIP_REDUNDANT=0 -> full 4-cycle s pulse occurs.
- Back-to-back: req_valid held 1 with alternating req_val=0/1 for 4 commands -> r and s pulses alternate, never overlap, and have at least 4 idle-low cycles between them (GUARD_W=2 plus DONE and IDLE). Count exactly 4 done pulses.
- Reset mid-pulse: assert rst=0 in the 2nd cycle of an r pulse -> r=0 from that edge, state IDLE, shadow=0, no done pulse.
- GUARD_W=0, PULSE_W=1: handshake at N -> 1-cycle pulse at N+1, done at N+2, req_ready at N+3; req_val changing during busy is ignored.
